// File: rtl/instruction_fetch_unit.sv
// Fetch stage: holds the PC, addresses the instruction ROM and queues {pc, instr} for decode.
// Optional `HALT_DETECT_EN: a fetched all-zero word halts fetch until the next redirect.
module instruction_fetch_unit #(
    parameter int                PC_WIDTH  = 32,
    parameter int                IMEM_AW   = 8,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    parameter int                BUF_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall_i,
    input  logic                redirect_i,
    input  logic [PC_WIDTH-1:0] redirect_pc_i,
    output logic [IMEM_AW-1:0]  imem_addr_o,
    input  logic [31:0]         imem_rd_i,
    output logic                id_valid_o,
    input  logic                id_ready_i,
    output logic [31:0]         id_instr_o,
    output logic [PC_WIDTH-1:0] id_pc_o,
    output logic [PC_WIDTH-1:0] id_pc_plus4_o,
    output logic                halted_o
);
    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {S_RUN, S_HALTED} state_t;

    state_t              r_state, w_next_state;
    logic [PC_WIDTH-1:0] r_pc;
    logic [PC_WIDTH-1:0] r_buf_pc    [BUF_DEPTH];
    logic [31:0]         r_buf_instr [BUF_DEPTH];
    logic [PW-1:0]       r_rd_ptr, r_wr_ptr;
    logic [CW-1:0]       r_count;

    logic w_run, w_valid, w_pop, w_room, w_fetch, w_halt_hit, w_push;

    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid & id_ready_i;
    // A pop in the same cycle frees a slot, so a full buffer can still accept.
    assign w_room  = (r_count < CW'(BUF_DEPTH)) | w_pop;
    assign w_fetch = w_run & ~stall_i & ~redirect_i & w_room;
`ifdef HALT_DETECT_EN
    assign w_halt_hit = w_fetch & (imem_rd_i == 32'h0);
`else
    assign w_halt_hit = 1'b0;
`endif
    assign w_push = w_fetch & ~w_halt_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_RUN;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_RUN:    if (w_halt_hit) w_next_state = S_HALTED;
            S_HALTED: if (redirect_i) w_next_state = S_RUN;
            default:  w_next_state = S_RUN;
        endcase
    end

    always_comb begin
        w_run = (r_state == S_RUN);
`ifdef HALT_DETECT_EN
        halted_o = (r_state == S_HALTED);
`else
        halted_o = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc     <= RESET_PC;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (redirect_i) begin
            r_pc     <= redirect_pc_i & ~PC_WIDTH'(3);
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_pc     <= r_pc + PC_WIDTH'(4);
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Storage needs no reset: outputs are masked while the buffer is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf_pc[r_wr_ptr]    <= r_pc;
            r_buf_instr[r_wr_ptr] <= imem_rd_i;
        end
    end

    assign imem_addr_o   = r_pc[IMEM_AW+1:2];
    assign id_valid_o    = w_valid;
    assign id_instr_o    = w_valid ? r_buf_instr[r_rd_ptr] : '0;
    assign id_pc_o       = w_valid ? r_buf_pc[r_rd_ptr] : '0;
    assign id_pc_plus4_o = w_valid ? (r_buf_pc[r_rd_ptr] + PC_WIDTH'(4)) : '0;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: directed segments queue expected
// {pc, instr}; a negedge monitor checks every decode handshake against the queue.
module tb_instruction_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n, stall_i, redirect_i, id_ready_i;
    logic [31:0] redirect_pc_i;
    logic [7:0]  imem_addr_o;
    logic [31:0] imem_rd_i, id_instr_o, id_pc_o, id_pc_plus4_o;
    logic        id_valid_o, halted_o;

    logic [31:0] rom [256];
    assign imem_rd_i = rom[imem_addr_o];

    typedef struct packed {logic [31:0] pc; logic [31:0] instr;} exp_t;
    exp_t exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    instruction_fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i), .imem_addr_o(imem_addr_o), .imem_rd_i(imem_rd_i),
        .id_valid_o(id_valid_o), .id_ready_i(id_ready_i), .id_instr_o(id_instr_o),
        .id_pc_o(id_pc_o), .id_pc_plus4_o(id_pc_plus4_o), .halted_o(halted_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_pc(input logic [31:0] pc);
        exp_q.push_back({pc, rom[pc[9:2]]});
    endtask

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Async reset asserted mid-cycle: outputs must clear before any clock edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        check("rst_valid", {31'b0, id_valid_o}, 32'd0);
        check("rst_pc", id_pc_o, 32'd0);
        check("rst_instr", id_instr_o, 32'd0);
        check("rst_pc4", id_pc_plus4_o, 32'd0);
        check("rst_addr", {24'b0, imem_addr_o}, 32'd0);
        check("rst_halted", {31'b0, halted_o}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n && id_valid_o && id_ready_i) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL sb_unexpected: got pc %h instr %h, expected nothing", id_pc_o, id_instr_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if ({id_pc_o, id_instr_o, id_pc_plus4_o} !== {e.pc, e.instr, e.pc + 32'd4}) begin
                    n_bad++;
                    $display("FAIL sb_entry: got pc %h instr %h pc4 %h, expected pc %h instr %h pc4 %h",
                             id_pc_o, id_instr_o, id_pc_plus4_o, e.pc, e.instr, e.pc + 32'd4);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = {8'hA5, 16'h0013, i[7:0]};
        rom[0]  = 32'h00A00093;
        rom[1]  = 32'h01400113;
        rom[2]  = 32'h01E00193;
        rom[15] = 32'h00000000;
        rst_n = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0; id_ready_i = 1'b0;
        cycles(2);

        // T1: streaming fetch, one instruction per cycle
        id_ready_i = 1'b1;
        expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8);
        do_reset();
        cycles(1);
        check("t1_instr", id_instr_o, 32'h00A00093);
        check("t1_pc4", id_pc_plus4_o, 32'h4);
        cycles(3);
        id_ready_i = 1'b0;
        check("t1_drained", exp_q.size(), 32'd0);

        // T2: decode backpressure saturates the buffer, nothing lost on release
        do_reset();
        cycles(5);
        check("t2_addr_hold", {24'b0, imem_addr_o}, 32'd2);
        check("t2_head_pc", id_pc_o, 32'h0);
        expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8); expect_pc(32'hC);
        id_ready_i = 1'b1;
        cycles(4);
        id_ready_i = 1'b0;
        check("t2_drained", exp_q.size(), 32'd0);

        // T3: stall at pc 0x10
        id_ready_i = 1'b1;
        expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8); expect_pc(32'hC); expect_pc(32'h10);
        do_reset();
        cycles(4);
        stall_i = 1'b1;
        check("t3_addr_stall", {24'b0, imem_addr_o}, 32'd4);
        cycles(3);
        check("t3_empty", {31'b0, id_valid_o}, 32'd0);
        check("t3_addr_held", {24'b0, imem_addr_o}, 32'd4);
        stall_i = 1'b0;
        cycles(1);
        check("t3_resume_pc", id_pc_o, 32'h10);
        cycles(1);
        id_ready_i = 1'b0;
        check("t3_drained", exp_q.size(), 32'd0);

        // T4: redirect flushes two buffered entries; unaligned target
        do_reset();
        cycles(2);
        check("t4_buffered", {31'b0, id_valid_o}, 32'd1);
        redirect_i = 1'b1; redirect_pc_i = 32'h48;
        cycles(1);
        redirect_i = 1'b0;
        check("t4_flushed", {31'b0, id_valid_o}, 32'd0);
        id_ready_i = 1'b1;
        expect_pc(32'h48); expect_pc(32'h48);
        cycles(1);
        check("t4_target_pc", id_pc_o, 32'h48);
        redirect_i = 1'b1; redirect_pc_i = 32'h4A;
        cycles(1);
        redirect_i = 1'b0;
        check("t4_flushed2", {31'b0, id_valid_o}, 32'd0);
        check("t4_addr_aligned", {24'b0, imem_addr_o}, 32'h12);
        cycles(1);
        check("t4_aligned_pc", id_pc_o, 32'h48);
        cycles(1);
        id_ready_i = 1'b0;
        check("t4_drained", exp_q.size(), 32'd0);

        // T5: ROM address wrap at pc 0x3FC
        do_reset();
        redirect_i = 1'b1; redirect_pc_i = 32'h3FC;
        cycles(1);
        redirect_i = 1'b0;
        id_ready_i = 1'b1;
        check("t5_addr_top", {24'b0, imem_addr_o}, 32'hFF);
        expect_pc(32'h3FC); expect_pc(32'h400);
        cycles(1);
        check("t5_addr_wrap", {24'b0, imem_addr_o}, 32'd0);
        cycles(1);
        check("t5_pc_400", id_pc_o, 32'h400);
        check("t5_pc4_404", id_pc_plus4_o, 32'h404);
        check("t5_instr_w0", id_instr_o, 32'h00A00093);
        cycles(1);
        id_ready_i = 1'b0;
        check("t5_drained", exp_q.size(), 32'd0);

        // T6: zero word at ROM[15]
        id_ready_i = 1'b1;
`ifdef HALT_DETECT_EN
        for (int i = 0; i < 15; i++) expect_pc(32'(i * 4));
        do_reset();
        cycles(16);
        check("t6_halted", {31'b0, halted_o}, 32'd1);
        check("t6_no_zero_entry", {31'b0, id_valid_o}, 32'd0);
        cycles(2);
        check("t6_still_halted", {31'b0, halted_o}, 32'd1);
        check("t6_pc_hold", {24'b0, imem_addr_o}, 32'hF);
        check("t6_still_empty", {31'b0, id_valid_o}, 32'd0);
        redirect_i = 1'b1; redirect_pc_i = 32'h0;
        expect_pc(32'h0);
        cycles(1);
        redirect_i = 1'b0;
        check("t6_unhalted", {31'b0, halted_o}, 32'd0);
        cycles(1);
        check("t6_restart_pc", id_pc_o, 32'h0);
        cycles(1);
`else
        for (int i = 0; i < 17; i++) expect_pc(32'(i * 4));
        do_reset();
        cycles(17);
        check("t6_not_halted", {31'b0, halted_o}, 32'd0);
        check("t6_past_zero_pc", id_pc_o, 32'h40);
        cycles(1);
`endif
        id_ready_i = 1'b0;
        check("t6_drained", exp_q.size(), 32'd0);

        do_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
